// File: rtl/program_loader.sv
// Program loader: clears program memory, then streams a little-endian length,
// the program bytes and an 8-bit additive checksum from a UART byte stream.
module program_loader #(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_write_enable,
    output logic [7:0]  mem_write_data,
    output logic [31:0] mem_write_address,
    output logic        mem_clear,
    output logic        cpu_hold,
    output logic        busy,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  error_code,
    output logic [31:0] bytes_written
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   MAX_LEN = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic [31:0]   len_r, len_s;
    logic [31:0]   len_full_s;
    logic [1:0]    len_idx_r, len_idx_s;
    logic [7:0]    sum_r, sum_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;
    logic          we_s;
    logic [7:0]    wdata_s;
    logic [31:0]   waddr_s;
    logic [1:0]    code_s;
    logic [31:0]   count_s;

    // Next-state, datapath and write-port decode
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        len_idx_s  = len_idx_r;
        sum_s      = sum_r;
        to_cnt_s   = to_cnt_r;
        we_s       = 1'b0;
        wdata_s    = mem_write_data;
        waddr_s    = mem_write_address;
        code_s     = error_code;
        count_s    = bytes_written;
        // Length bytes shift in from the top so the first byte lands in [7:0]
        len_full_s = {rx_data, len_r[31:8]};

        if (load_start && (state_r != S_CLEAR)) begin
            state_s   = S_CLEAR;
            len_s     = 32'd0;
            len_idx_s = 2'd0;
            sum_s     = 8'd0;
            to_cnt_s  = '0;
            code_s    = 2'b00;
            count_s   = 32'd0;
        end else begin
            case (state_r)
                S_IDLE:  state_s = S_IDLE;
                S_CLEAR: state_s = S_LEN;
                S_LEN, S_DATA, S_CHK: begin
                    if (!rx_valid) begin
                        if (to_cnt_r == TO_LAST) begin
                            state_s = S_ERROR;
                            code_s  = 2'b11;
                        end else begin
                            to_cnt_s = to_cnt_r + TW'(1);
                        end
                    end else begin
                        to_cnt_s = '0;
                        case (state_r)
                            S_LEN: begin
                                len_s     = len_full_s;
                                len_idx_s = len_idx_r + 2'd1;
                                if (len_idx_r == 2'd3) begin
                                    if (len_full_s > MAX_LEN) begin
                                        state_s = S_ERROR;
                                        code_s  = 2'b01;
                                    end else if (len_full_s == 32'd0) begin
                                        state_s = S_CHK;
                                    end else begin
                                        state_s = S_DATA;
                                    end
                                end else begin
                                    state_s = S_LEN;
                                end
                            end
                            S_DATA: begin
                                we_s    = 1'b1;
                                wdata_s = rx_data;
                                waddr_s = bytes_written;
                                count_s = bytes_written + 32'd1;
                                sum_s   = sum_r + rx_data;
                                if ((bytes_written + 32'd1) == len_r) begin
                                    state_s = S_CHK;
                                end else begin
                                    state_s = S_DATA;
                                end
                            end
                            S_CHK: begin
                                if (rx_data == sum_r) begin
                                    state_s = S_DONE;
                                end else begin
                                    state_s = S_ERROR;
                                    code_s  = 2'b10;
                                end
                            end
                            default: state_s = S_IDLE;
                        endcase
                    end
                end
                S_DONE:  state_s = S_IDLE;
                S_ERROR: state_s = S_ERROR;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r           <= S_IDLE;
            len_r             <= 32'd0;
            len_idx_r         <= 2'd0;
            sum_r             <= 8'd0;
            to_cnt_r          <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_data    <= 8'd0;
            mem_write_address <= 32'd0;
            mem_clear         <= 1'b0;
            cpu_hold          <= 1'b0;
            busy              <= 1'b0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
            error_code        <= 2'b00;
            bytes_written     <= 32'd0;
        end else begin
            state_r           <= state_s;
            len_r             <= len_s;
            len_idx_r         <= len_idx_s;
            sum_r             <= sum_s;
            to_cnt_r          <= to_cnt_s;
            mem_write_enable  <= we_s;
            mem_write_data    <= wdata_s;
            mem_write_address <= waddr_s;
            mem_clear         <= (state_s == S_CLEAR);
            cpu_hold          <= (state_s != S_IDLE);
            busy              <= (state_s inside {S_CLEAR, S_LEN, S_DATA, S_CHK});
            load_done         <= (state_s == S_DONE);
            load_error        <= (state_s == S_ERROR);
            error_code        <= code_s;
            bytes_written     <= count_s;
        end
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Sequences writes into the byte-wide program memory from a serial byte stream (UART receiver output). It clears the memory, then receives a little-endian 32-bit length, the program bytes and an 8-bit checksum. It drives the memory's write_enable, write_data, write_address and clear_mem ports, and holds the CPU stalled while a load is in progress. It sits between the UART RX block and program_memory, next to the core's reset/stall logic.

Parameters:
MEM_BYTES, 1024, program memory size in bytes; largest legal length.
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes in LEN/DATA/CHK before abort.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
load_start  input  1  one-cycle pulse; begin a new load (also aborts/restarts any load in progress)
rx_valid  input  1  one-cycle strobe; rx_data holds a valid byte (no backpressure)
rx_data  input  8  received byte
mem_write_enable  output  1  to program memory write_enable
mem_write_data  output  8  to program memory write_data
mem_write_address  output  32  to program memory write_address
mem_clear  output  1  to program memory clear_mem
cpu_hold  output  1  high while the CPU must not fetch or execute
busy  output  1  state is not IDLE, DONE or ERROR
load_done  output  1  one-cycle pulse on successful load
load_error  output  1  level; high in ERROR state
error_code  output  2  00 none, 01 length too large, 10 checksum mismatch, 11 timeout
bytes_written  output  32  count of data bytes written in the current/last load

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a clk edge) forces state IDLE and all outputs to 0, including error_code=00 and bytes_written=0. A reset mid-load produces no write on the following cycle.
- States: IDLE, CLEAR, LEN, DATA, CHK, DONE, ERROR.
- IDLE: cpu_hold=0 and rx_valid is ignored. load_start -> CLEAR.
- CLEAR: one cycle; mem_clear=1 for exactly that cycle and cpu_hold=1. Clears error_code, bytes_written, the length register, the byte index, the running sum and the timeout counter. Next state LEN; an rx_valid in this cycle is dropped.
- LEN: collects 4 bytes, first byte into len[7:0] (little-endian). After the 4th byte:
  - len > MEM_BYTES -> ERROR, code 01.
  - len == 0 -> CHK.
  - otherwise -> DATA.
- DATA:
  - Each rx_valid produces, on the next cycle, mem_write_enable=1 for one cycle, mem_write_data=rx_data, mem_write_address=index (starting at 0).
  - index increments by 1 and bytes_written increments on the same cycle as the write.
  - sum = (sum + rx_data) mod 256.
  - After the len-th byte is accepted -> CHK. The final write still issues one cycle later.
- CHK: the next rx_valid byte is compared with sum[7:0]. Equal -> DONE; otherwise -> ERROR, code 10. With len==0 the expected checksum is 0x00.
- DONE: load_done=1 for one cycle with cpu_hold=1, then IDLE (cpu_hold=0 the following cycle).
- ERROR: load_error=1 and cpu_hold=1 until load_start (-> CLEAR). rx_valid is ignored.
- Timeout: in LEN/DATA/CHK a counter increments each cycle without rx_valid and resets on rx_valid. When it reaches TIMEOUT_CYCLES -> ERROR, code 11.
- load_start in any state other than CLEAR -> CLEAR; in CLEAR it is ignored. load_start wins over a simultaneous rx_valid, and that byte is dropped (no write issued).
- cpu_hold is 1 in CLEAR, LEN, DATA, CHK, DONE and ERROR.
- mem_write_enable is never asserted in the same cycle as mem_clear.
- Width rules: len and bytes_written are 32 bits; the comparison with MEM_BYTES is unsigned; mem_write_address never exceeds MEM_BYTES-1.

Test Plan:
- Reset then load_start; send len 03 00 00 00, data 13 00 A0 and checksum B3 -> one mem_clear cycle; writes (0,0x13), (1,0x00), (2,0xA0) each 1 cycle after its rx_valid; load_done pulse; bytes_written=3; cpu_hold falls the cycle after DONE.
- Send len 01 04 00 00 (1025) with MEM_BYTES=1024 -> ERROR, error_code=01, no writes, cpu_hold stays 1; a following load_start re-clears and restarts.
- Send len 02 00 00 00, data 01 02, checksum 04 -> error_code=10, both writes issued, load_error=1.
- TIMEOUT_CYCLES=16: send len bytes then stay silent 16 cycles -> ERROR, code 11; with len=0 and checksum 00 instead -> DONE.
- Mid-DATA, assert load_start together with rx_valid -> no write for that byte, mem_clear pulses, address restarts at 0 on the new stream.
- Drive rst_n=0 on the same cycle as a DATA rx_valid -> next cycle mem_write_enable=0, all outputs 0, state IDLE.
